fx2_slave_fifo: RTL and testbench
=================================

FX2_SLAVE_FIFO -- requirements
Module: fx2_slave_fifo

Interface
REQ-001 Parameter OUT_ADDR, default 2'b00, FIFOADR of the host->device (OUT) endpoint FIFO.
REQ-002 Parameter IN_ADDR, default 2'b10, FIFOADR of the device->host (IN) endpoint FIFO.
REQ-003 Parameter BURST, default 16, max consecutive transfers in one direction while the other direction has work.
REQ-004 Clock and reset: ifclk is the single clock; reset is asynchronous and active-high.
REQ-005 Port ifclk  in  1  FX2 interface clock; all logic on its rising edge.
REQ-006 Port reset  in  1  asynchronous active-high reset.
REQ-007 Port fifoadr  out  2  FX2 endpoint select.
REQ-008 Port fx2_data_in  in  8  read data from the selected OUT FIFO, valid combinationally before the read edge.
REQ-009 Port fx2_data_out  out  8  write data to the IN FIFO.
REQ-010 Port fx2_data_oe  out  1  data-bus output enable, high only in WR_SETUP, WR and PKTEND.
REQ-011 Port slrd / slwr / pktend / sloe  out  1 each  FX2 strobes; all active-high.
REQ-012 Port fx2_empty  in  1  OUT FIFO empty flag; fx2_full  in  1  IN FIFO full flag.
REQ-013 Port rx_data  out  8, rx_valid  out  1, rx_ready  in  1  host->device byte stream, valid/ready.
REQ-014 Port tx_data  in  8, tx_valid  in  1, tx_ready  out  1  device->host byte stream, valid/ready.
REQ-015 Port tx_flush  in  1  single-cycle request to commit the current IN packet.

Function
REQ-016 States IDLE, RD_SETUP, RD, WR_SETUP, WR, PKTEND.
REQ-017 fifoadr, sloe, fx2_data_oe: registered. slrd, slwr, pktend, tx_ready: combinational from registered state and current inputs.
REQ-018 rx_space = !rx_valid || rx_ready; rx_work = !fx2_empty && rx_space; tx_work = tx_valid || flush_pending.
REQ-019 IDLE: rx_work and (last grant WR or !tx_work) -> RD_SETUP; else tx_work -> WR_SETUP; else stay.
REQ-020 RD_SETUP: fifoadr=OUT_ADDR, sloe=1, no strobe; one cycle -> RD.
REQ-021 RD: slrd = rx_work; on that edge rx_data <= fx2_data_in, rx_valid <= 1, burst count +1.
REQ-022 RD exit to IDLE: fx2_empty, or !rx_space with tx_work, or burst count == BURST with tx_work.
REQ-023 rx_valid clears on rx_valid && rx_ready with no new slrd in the same cycle.
REQ-024 WR_SETUP: fifoadr=IN_ADDR, fx2_data_oe=1, no strobe; one cycle -> WR.
REQ-025 WR: tx_ready = !fx2_full; slwr = tx_valid && !fx2_full; fx2_data_out = tx_data; pkt_cnt +1 per slwr.
REQ-026 pkt_cnt is 9 bits and wraps 511 -> 0, matching the FX2 auto-commit at 512 bytes.
REQ-027 WR exit: !tx_valid && flush_pending -> PKTEND; !tx_valid && !flush_pending -> IDLE; burst count == BURST with rx_work -> IDLE.
REQ-028 PKTEND: if pkt_cnt != 0 and !fx2_full, pktend=1 for exactly one cycle; if pkt_cnt == 0, no pktend (no zero-length packets).
REQ-029 PKTEND: while fx2_full, hold. Leaving PKTEND clears flush_pending and pkt_cnt, then -> IDLE.
REQ-030 tx_flush sets flush_pending. If tx_flush coincides with the PKTEND exit, flush_pending stays set for a new packet.
REQ-031 Burst count clears on every entry to RD_SETUP or WR_SETUP; last-grant records the most recent setup state.
REQ-032 slrd and slwr are never both high; no strobe in the cycle in which fifoadr changes.

Reset
REQ-033 On reset: state=IDLE, fifoadr=OUT_ADDR, sloe=0, fx2_data_oe=0, slrd=slwr=pktend=0, rx_valid=0, rx_data=0, fx2_data_out=0.
REQ-034 On reset: tx_ready=0, pkt_cnt=0, burst count=0, flush_pending=0, last grant=WR.
REQ-035 Reset mid-burst aborts immediately; a partially written IN packet is not committed.

Verification
REQ-036 OUT FIFO holds 3 bytes 0x11,0x22,0x33, rx_ready=1 -> RD_SETUP, then 3 consecutive slrd; rx_data 0x11,0x22,0x33; return to IDLE on fx2_empty.
REQ-037 tx_valid for 4 bytes 0xA0..0xA3, then tx_flush -> WR_SETUP, 4 slwr with matching data, one pktend pulse, pkt_cnt returns to 0.
REQ-038 tx_flush with pkt_cnt=0 -> no pktend; flush_pending cleared; FSM back in IDLE.
REQ-039 Both directions saturated, BURST=16 -> alternating 16-byte bursts, each preceded by one setup cycle, never simultaneous strobes.
REQ-040 Write 512 bytes then tx_flush -> pkt_cnt wraps to 0 and no pktend issued; fx2_full high during WR -> tx_ready=0, no slwr until full drops.
REQ-041 Assert reset during RD with rx_valid=1 -> all outputs at reset values asynchronously; first post-reset cycle in IDLE.

Source files
------------

// File: rtl/fx2_slave_fifo.sv
// Cypress FX2 slave-FIFO master: bridges an OUT endpoint to an rx byte stream and a tx byte
// stream to an IN endpoint, arbitrating the shared bus in bounded bursts.
module fx2_slave_fifo #(
  parameter logic [1:0]  OUT_ADDR = 2'b00,
  parameter logic [1:0]  IN_ADDR  = 2'b10,
  parameter int unsigned BURST    = 16
) (
  input  logic       ifclk,
  input  logic       reset,
  output logic [1:0] fifoadr,
  input  logic [7:0] fx2_data_in,
  output logic [7:0] fx2_data_out,
  output logic       fx2_data_oe,
  output logic       slrd,
  output logic       slwr,
  output logic       pktend,
  output logic       sloe,
  input  logic       fx2_empty,
  input  logic       fx2_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_flush
);

  localparam int unsigned BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] BurstMax = BW'(BURST);

  typedef enum logic [2:0] {
    StIdle, StRdSetup, StRd, StWrSetup, StWr, StPktend
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    fifoadr_q, fifoadr_d;
  logic          sloe_q, sloe_d, oe_q, oe_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic [8:0]    pkt_q, pkt_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          flush_q, flush_d;
  logic          last_wr_q, last_wr_d;
  logic          rx_space, rx_work, tx_work, burst_done;

  always_comb begin
    rx_space     = !rx_valid_q || rx_ready;
    rx_work      = !fx2_empty && rx_space;
    tx_work      = tx_valid || flush_q;
    burst_done   = (burst_q == BurstMax);
    state_d      = state_q;
    slrd         = 1'b0;
    slwr         = 1'b0;
    pktend       = 1'b0;
    tx_ready     = 1'b0;
    fx2_data_out = 8'h00;
    burst_d      = burst_q;
    last_wr_d    = last_wr_q;
    pkt_d        = pkt_q;
    flush_d      = flush_q | tx_flush;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;

    case (state_q)
      StIdle: begin
        if (rx_work && (last_wr_q || !tx_work)) begin
          state_d   = StRdSetup;
          burst_d   = '0;
          last_wr_d = 1'b0;
        end else if (tx_work) begin
          state_d   = StWrSetup;
          burst_d   = '0;
          last_wr_d = 1'b1;
        end
      end
      StRdSetup: state_d = StRd;
      StRd: begin
        if (fx2_empty || (!rx_space && tx_work) || (burst_done && tx_work)) begin
          state_d = StIdle;
        end else begin
          slrd = rx_work;
        end
      end
      StWrSetup: state_d = StWr;
      StWr: begin
        fx2_data_out = tx_data;
        // Stop offering tx while yielding the bus to a waiting read burst.
        tx_ready     = !fx2_full && !(burst_done && rx_work);
        slwr         = tx_valid && tx_ready;
        if (!tx_valid) begin
          state_d = flush_q ? StPktend : StIdle;
        end else if (burst_done && rx_work) begin
          state_d = StIdle;
        end
      end
      StPktend: begin
        if (!fx2_full) begin
          pktend  = (pkt_q != 9'd0);
          state_d = StIdle;
          pkt_d   = 9'd0;
          flush_d = tx_flush;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((slrd || slwr) && !burst_done) burst_d = burst_q + 1'b1;
    if (slwr) pkt_d = pkt_q + 9'd1;

    if (slrd) begin
      rx_data_d  = fx2_data_in;
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    sloe_d    = (state_d == StRdSetup) || (state_d == StRd);
    oe_d      = (state_d == StWrSetup) || (state_d == StWr) || (state_d == StPktend);
    fifoadr_d = oe_d ? IN_ADDR : (sloe_d ? OUT_ADDR : fifoadr_q);
  end

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      fifoadr_q  <= OUT_ADDR;
      sloe_q     <= 1'b0;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      pkt_q      <= 9'd0;
      burst_q    <= '0;
      flush_q    <= 1'b0;
      last_wr_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      fifoadr_q  <= fifoadr_d;
      sloe_q     <= sloe_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      pkt_q      <= pkt_d;
      burst_q    <= burst_d;
      flush_q    <= flush_d;
      last_wr_q  <= last_wr_d;
    end
  end

  assign fifoadr     = fifoadr_q;
  assign sloe        = sloe_q;
  assign fx2_data_oe = oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_fx2_slave_fifo.sv
// Directed bench for fx2_slave_fifo with a small FX2 OUT-FIFO model and strobe monitors.
module tb_fx2_slave_fifo;

  logic       ifclk = 1'b0;
  logic       reset;
  logic [1:0] fifoadr;
  logic [7:0] fx2_data_in, fx2_data_out, rx_data, tx_data;
  logic       fx2_data_oe, slrd, slwr, pktend, sloe;
  logic       fx2_empty, fx2_full, rx_valid, rx_ready, tx_valid, tx_ready, tx_flush;

  fx2_slave_fifo dut (
    .ifclk(ifclk), .reset(reset), .fifoadr(fifoadr), .fx2_data_in(fx2_data_in),
    .fx2_data_out(fx2_data_out), .fx2_data_oe(fx2_data_oe), .slrd(slrd), .slwr(slwr),
    .pktend(pktend), .sloe(sloe), .fx2_empty(fx2_empty), .fx2_full(fx2_full),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush)
  );

  always #5 ifclk = ~ifclk;

  // OUT FIFO model
  logic [7:0] out_mem [0:255];
  int         out_wr_idx = 0;
  int         out_rd_idx = 0;
  logic       fifo_clear = 1'b0;
  assign fx2_data_in = out_mem[out_rd_idx & 255];
  assign fx2_empty   = (out_rd_idx == out_wr_idx);
  always @(posedge ifclk) begin
    if (fifo_clear) out_rd_idx <= out_wr_idx;
    else if (slrd) out_rd_idx <= out_rd_idx + 1;
  end

  // Monitors
  int         rd_cnt = 0, wr_cnt = 0, pe_cnt = 0, rx_n = 0, both_err = 0;
  logic [7:0] wr_log [0:1023];
  logic [7:0] rx_log [0:255];
  logic       run_en = 1'b0, cur_rd = 1'b0;
  int         run_len = 0, run_n = 0;
  int         runs [0:15];
  always @(negedge ifclk) begin
    if (slrd) rd_cnt <= rd_cnt + 1;
    if (slwr) begin
      wr_log[wr_cnt & 1023] <= fx2_data_out;
      wr_cnt <= wr_cnt + 1;
    end
    if (pktend) pe_cnt <= pe_cnt + 1;
    if (slrd && slwr) both_err <= both_err + 1;
    if (rx_valid && rx_ready) begin
      rx_log[rx_n & 255] <= rx_data;
      rx_n <= rx_n + 1;
    end
    if (run_en && (slrd || slwr)) begin
      if (run_len != 0 && slrd == cur_rd) begin
        run_len <= run_len + 1;
      end else begin
        if (run_len != 0 && run_n < 16) begin
          runs[run_n] <= run_len;
          run_n <= run_n + 1;
        end
        run_len <= 1;
        cur_rd  <= slrd;
      end
    end
  end

  int n_cmp = 0, n_err = 0, to_cnt = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ifclk);
      #2;
    end
  endtask

  task automatic load(input logic [7:0] d);
    out_mem[out_wr_idx & 255] = d;
    out_wr_idx++;
  endtask

  // Present one byte and hold it until the handshake edge has passed.
  task automatic send_byte(input logic [7:0] d);
    int k;
    tx_data  = d;
    tx_valid = 1'b1;
    k = 0;
    do begin
      @(negedge ifclk);
      k++;
    end while (!tx_ready && k < 60);
    if (!tx_ready) to_cnt++;
    @(posedge ifclk);
    #2;
  endtask

  task automatic flush_pulse();
    tx_flush = 1'b1;
    tick(1);
    tx_flush = 1'b0;
  endtask

  initial begin
    int rd0, wr0, pe0, rx0, oe_sum;
    reset = 1'b1; rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    tx_flush = 1'b0; fx2_full = 1'b0;
    tick(3);
    @(negedge ifclk);
    chk8("rst_fifoadr", {6'd0, fifoadr}, 8'h00);
    chk1("rst_sloe", sloe, 1'b0);
    chk1("rst_oe", fx2_data_oe, 1'b0);
    chk1("rst_slrd", slrd, 1'b0);
    chk1("rst_slwr", slwr, 1'b0);
    chk1("rst_pktend", pktend, 1'b0);
    chk1("rst_tx_ready", tx_ready, 1'b0);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk8("rst_data_out", fx2_data_out, 8'h00);
    tick(1);
    reset = 1'b0;
    tick(2);

    // Three-byte read from the OUT FIFO
    rd0 = rd_cnt; rx0 = rx_n;
    load(8'h11); load(8'h22); load(8'h33);
    @(negedge ifclk);
    @(negedge ifclk);
    chk1("rdsetup_sloe", sloe, 1'b1);
    chk1("rdsetup_no_slrd", slrd, 1'b0);
    chk8("rdsetup_adr", {6'd0, fifoadr}, 8'h00);
    @(negedge ifclk);
    chk1("rd_slrd", slrd, 1'b1);
    for (int k = 0; k < 40 && !(fx2_empty && !rx_valid && !sloe); k++) tick(1);
    tick(2);
    chk1("t1_idle", sloe, 1'b0);
    chki("t1_reads", rd_cnt - rd0, 3);
    chki("t1_rx_count", rx_n - rx0, 3);
    chk8("t1_rx0", rx_log[rx0], 8'h11);
    chk8("t1_rx1", rx_log[rx0 + 1], 8'h22);
    chk8("t1_rx2", rx_log[rx0 + 2], 8'h33);
    chk1("t1_rx_valid_clr", rx_valid, 1'b0);

    // Four-byte packet committed with pktend
    wr0 = wr_cnt; pe0 = pe_cnt;
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
    tx_valid = 1'b0;
    flush_pulse();
    for (int k = 0; k < 40 && pe_cnt == pe0; k++) tick(1);
    tick(6);
    chki("t2_writes", wr_cnt - wr0, 4);
    chk8("t2_d0", wr_log[wr0], 8'hA0);
    chk8("t2_d1", wr_log[wr0 + 1], 8'hA1);
    chk8("t2_d2", wr_log[wr0 + 2], 8'hA2);
    chk8("t2_d3", wr_log[wr0 + 3], 8'hA3);
    chki("t2_pktend", pe_cnt - pe0, 1);
    chk1("t2_idle", fx2_data_oe, 1'b0);

    // Flush with empty packet: no pktend, flush cleared
    pe0 = pe_cnt;
    flush_pulse();
    tick(10);
    oe_sum = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge ifclk);
      oe_sum += int'(fx2_data_oe);
    end
    tick(1);
    chki("t3_no_pktend", pe_cnt - pe0, 0);
    chki("t3_flush_cleared", oe_sum, 0);

    // IN FIFO full stalls writes; then 512 bytes wrap pkt_cnt
    wr0 = wr_cnt; pe0 = pe_cnt;
    fx2_full = 1'b1; tx_valid = 1'b1; tx_data = 8'h00;
    tick(5);
    @(negedge ifclk);
    chk1("t4_full_oe", fx2_data_oe, 1'b1);
    chk8("t4_full_adr", {6'd0, fifoadr}, 8'h02);
    chk1("t4_full_tx_ready", tx_ready, 1'b0);
    chk1("t4_full_slwr", slwr, 1'b0);
    @(posedge ifclk);
    #2;
    fx2_full = 1'b0;
    @(negedge ifclk);
    chk1("t4_free_tx_ready", tx_ready, 1'b1);
    chk1("t4_free_slwr", slwr, 1'b1);
    @(posedge ifclk);
    #2;
    for (int i = 1; i < 512; i++) send_byte(8'(i));
    tx_valid = 1'b0;
    flush_pulse();
    tick(12);
    chki("t4_writes", wr_cnt - wr0, 512);
    chk8("t4_first", wr_log[wr0 & 1023], 8'h00);
    chk8("t4_last", wr_log[(wr0 + 511) & 1023], 8'hFF);
    chki("t4_no_pktend", pe_cnt - pe0, 0);
    chk1("t4_idle", fx2_data_oe, 1'b0);

    // Both directions saturated: alternating bursts of 16
    for (int i = 0; i < 64; i++) load(8'(i));
    run_en = 1'b1; tx_valid = 1'b1; tx_data = 8'h5C;
    for (int k = 0; k < 600 && run_n < 4; k++) tick(1);
    run_en = 1'b0; tx_valid = 1'b0;
    chki("t5_runs", run_n, 4);
    chki("t5_run0_rd", runs[0], 16);
    chki("t5_run1_wr", runs[1], 16);
    chki("t5_run2_rd", runs[2], 16);
    chki("t5_run3_wr", runs[3], 16);
    for (int k = 0; k < 200 && !(fx2_empty && !rx_valid && !sloe && !fx2_data_oe); k++) tick(1);
    tick(2);
    chk1("t5_drained", fx2_empty && !sloe, 1'b1);

    // Reset during a stalled read with rx_valid held
    pe0 = pe_cnt;
    rx_ready = 1'b0;
    load(8'h5A); load(8'h5B);
    for (int k = 0; k < 20 && !rx_valid; k++) tick(1);
    tick(2);
    @(negedge ifclk);
    chk1("t6_rx_valid", rx_valid, 1'b1);
    chk8("t6_rx_data", rx_data, 8'h5A);
    chk1("t6_in_rd", sloe, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk1("t6_async_sloe", sloe, 1'b0);
    chk1("t6_async_rx_valid", rx_valid, 1'b0);
    chk8("t6_async_rx_data", rx_data, 8'h00);
    chk1("t6_async_slrd", slrd, 1'b0);
    chk8("t6_async_adr", {6'd0, fifoadr}, 8'h00);
    fifo_clear = 1'b1;
    tick(1);
    fifo_clear = 1'b0;
    tick(1);
    reset = 1'b0;
    rx_ready = 1'b1;
    @(negedge ifclk);
    chk1("t6_post_idle_sloe", sloe, 1'b0);
    chk1("t6_post_idle_oe", fx2_data_oe, 1'b0);
    tick(1);
    flush_pulse();
    tick(12);
    chki("t6_no_partial_commit", pe_cnt - pe0, 0);

    chki("never_both_strobes", both_err, 0);
    chki("tx_timeouts", to_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
